// File: rtl/cpu_data_mem_responder_if.sv
// Native CPU data-memory port: request channel (Address/MemWrite/MemRead with
// Mem_Req_Ready) and read response channel (Read_data/Read_data_Valid with
// Read_data_Ready). The CPU side is the master, the memory model the slave.
interface cpu_data_mem_responder_if;
   logic [31:0] Address;
   logic        MemWrite;
   logic [31:0] Write_data;
   logic [3:0]  Write_strb;
   logic        MemRead;
   logic        Mem_Req_Ready;
   logic [31:0] Read_data;
   logic        Read_data_Valid;
   logic        Read_data_Ready;

   modport master (
      output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
      input  Mem_Req_Ready, Read_data, Read_data_Valid
   );

   modport slave (
      input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
      output Mem_Req_Ready, Read_data, Read_data_Valid
   );
endinterface

// File: rtl/cpu_data_mem_responder.sv
// Behavioural data-memory responder for unit-level CPU simulation.
// Serves the native data port from a local word array, injects request and
// response stalls from random_mask, and keeps sticky error flags plus
// read/write traffic counters. One read is outstanding at a time.
module cpu_data_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter bit STALL_EN   = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [4:0]                  random_mask,
   cpu_data_mem_responder_if.slave     bus,
   output logic [31:0]                 rd_cnt,
   output logic [31:0]                 wr_cnt,
   output logic                        both_err,
   output logic                        oor_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [2:0]              stall_cnt;
   logic [2:0]              next_stall;
   logic [1:0]              dly;
   logic [1:0]              next_dly;
   logic [ADDR_WIDTH-1:0]   rd_index;
   logic                    rd_oor;

   logic [31:0]             mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   req_index;
   logic                    req_oor;
   logic                    req_ready;
   logic                    accept;
   logic                    accept_wr;
   logic                    accept_rd;
   logic                    accept_both;
   logic [2:0]              stall_reload;
   logic [1:0]              dly_load;
   logic [ADDR_WIDTH-1:0]   resp_index;
   logic                    resp_oor;
   logic                    load_resp;
   logic [31:0]             read_data;
   logic                    read_valid;
   logic                    unused_addr_bits;

   // Byte-lane merge of new write data into an existing word under the strobes.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] result;
      result = old_word;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            result[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            result[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return result;
   endfunction

   // The byte offset within a word plays no part in addressing.
   assign unused_addr_bits = &{1'b0, bus.Address[1:0]};

   assign req_index = bus.Address[ADDR_WIDTH+1:2];
   assign req_oor   = |bus.Address[31:ADDR_WIDTH+2];

   // Ready is held low throughout reset even though state already reads IDLE.
   assign req_ready   = (rst == 1'b0) && (state == IDLE) && (stall_cnt == 3'd0);
   assign accept      = req_ready && (bus.MemRead || bus.MemWrite);
   assign accept_wr   = accept && bus.MemWrite;
   assign accept_rd   = accept && bus.MemRead && !bus.MemWrite;
   assign accept_both = accept && bus.MemRead && bus.MemWrite;

   assign stall_reload = (STALL_EN && random_mask[4]) ? {1'b0, random_mask[3:2]} : 3'd0;
   assign dly_load     = STALL_EN ? random_mask[1:0] : 2'd0;

   assign bus.Mem_Req_Ready   = req_ready;
   assign bus.Read_data       = read_data;
   assign bus.Read_data_Valid = read_valid;

   // Next state, stall countdown and response delay countdown.
   always_comb begin
      next_state = state;
      next_stall = stall_cnt;
      next_dly   = dly;
      case (state)
         IDLE: begin
            if (accept_wr) begin
               next_stall = stall_reload;
            end else if (accept_rd) begin
               next_dly   = dly_load;
               next_state = (dly_load != 2'd0) ? RD_WAIT : RD_RESP;
            end else if (stall_cnt != 3'd0) begin
               next_stall = stall_cnt - 3'd1;
            end else begin
               next_stall = stall_cnt;
            end
         end
         RD_WAIT: begin
            if (dly == 2'd1) begin
               next_dly   = 2'd0;
               next_state = RD_RESP;
            end else begin
               next_dly   = dly - 2'd1;
            end
         end
         RD_RESP: begin
            if (read_valid && bus.Read_data_Ready) begin
               next_state = IDLE;
               next_stall = stall_reload;
            end else begin
               next_state = RD_RESP;
            end
         end
         default: begin
            next_state = IDLE;
            next_stall = 3'd0;
            next_dly   = 2'd0;
         end
      endcase
   end

   // The array word is fetched on the edge that enters RD_RESP; on a zero-delay
   // read that is the accepting edge, so the live request address is used.
   always_comb begin
      resp_index = rd_index;
      resp_oor   = rd_oor;
      if (state == IDLE) begin
         resp_index = req_index;
         resp_oor   = req_oor;
      end else begin
         resp_index = rd_index;
         resp_oor   = rd_oor;
      end
   end

   assign load_resp = (next_state == RD_RESP) && (state != RD_RESP);

   // FSM state, countdowns and the latched read target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         stall_cnt <= 3'd0;
         dly       <= 2'd0;
         rd_index  <= '0;
         rd_oor    <= 1'b0;
      end else begin
         state     <= next_state;
         stall_cnt <= next_stall;
         dly       <= next_dly;
         if (accept_rd) begin
            rd_index <= req_index;
            rd_oor   <= req_oor;
         end
      end
   end

   // Registered read response; data holds until the next response is loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_valid <= 1'b0;
         read_data  <= 32'd0;
      end else begin
         read_valid <= (next_state == RD_RESP);
         if (load_resp) begin
            read_data <= resp_oor ? 32'd0 : mem[resp_index];
         end
      end
   end

   // Traffic counters and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt   <= 32'd0;
         wr_cnt   <= 32'd0;
         both_err <= 1'b0;
         oor_err  <= 1'b0;
      end else begin
         if (accept_wr) begin
            wr_cnt <= wr_cnt + 32'd1;
         end
         if (accept_rd) begin
            rd_cnt <= rd_cnt + 32'd1;
         end
         if (accept_both) begin
            both_err <= 1'b1;
         end
         if (accept && req_oor) begin
            oor_err <= 1'b1;
         end
      end
   end

   // Array write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (accept_wr && !req_oor) begin
         mem[req_index] <= merge_bytes(mem[req_index], bus.Write_data, bus.Write_strb);
      end
   end

endmodule
